bram_8k8bit: RTL and testbench

Single-port synchronous block RAM, 8192 words × 8 bits, with a registered read port. It is the storage primitive behind the sample capture FIFO: four instances are banked on address bits [14:13] to form a 32 KiB sample buffer. Each access is gated by a per-bank enable, and each bank shares one write/read strobe.

---
 rtl/bram_8k8bit.sv | 64 ++++++
 tb/tb_bram_8k8bit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/bram_8k8bit.sv
// Single-port 8192x8 block RAM, read-first, registered read port.
// Define BRAM_OUTPUT_REG_EN to add a second, free-running output register (2-cycle read latency).
module bram_8k8bit #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // Array powers up zeroed; reset_n never clears it, only blocks writes.
    logic [DATA_W-1:0] mem_q [2**ADDR_W] = '{default: '0};

    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;
    logic              wr_d;

    // Reading the array before the write lands gives read-first behaviour.
    always_comb begin
        dout_d = dout_q;
        wr_d   = en && we;
        if (en) begin
            dout_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
            if (wr_d) begin
                mem_q[addr] <= din;
            end
        end
    end

`ifdef BRAM_OUTPUT_REG_EN
    logic [DATA_W-1:0] pipe_d;
    logic [DATA_W-1:0] pipe_q;

    always_comb begin
        pipe_d = dout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q;
`else
    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_bram_8k8bit.sv
// Directed self-checking bench for bram_8k8bit; honours BRAM_OUTPUT_REG_EN for read latency.
module tb_bram_8k8bit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;

    int vectors = 0;
    int miscompares = 0;

`ifdef BRAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    bram_8k8bit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Extra idle edge so the optional output register catches up.
    task automatic settle();
        en = 1'b0;
        we = 1'b0;
        if (LAT == 2) tick();
    endtask

    task automatic check(input string tag, input logic [7:0] expected);
        vectors++;
        assert (dout === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, dout, expected);
        end
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        en = 1'b1; we = 1'b1; addr = a; din = d;
        tick();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [12:0] a, input logic [7:0] expected);
        en = 1'b1; we = 1'b0; addr = a;
        tick();
        settle();
        check(tag, expected);
    endtask

    initial begin
        reset_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; din = '0;
        tick();
        tick();
        check("reset_state", 8'h00);
        reset_n = 1'b1;
        rd_chk("power_up_zero", 13'h0000, 8'h00);

        wr(13'h0010, 8'hA5);
        rd_chk("preload_a5", 13'h0010, 8'hA5);
        reset_n = 1'b0;
        #1;
        check("async_reset", 8'h00);
        tick();
        check("reset_hold", 8'h00);
        reset_n = 1'b1;
        rd_chk("read_after_reset", 13'h0000, 8'h00);

        wr(13'h0123, 8'h3C);
        rd_chk("write_read", 13'h0123, 8'h3C);

        wr(13'h1FFF, 8'h11);
        wr(13'h1FFF, 8'h22);
        settle();
        check("read_first", 8'h11);
        rd_chk("read_new", 13'h1FFF, 8'h22);

        en = 1'b0; we = 1'b1; din = 8'hFF; addr = 13'h0005;
        tick();
        settle();
        check("en_hold", 8'h22);
        rd_chk("en_gated_write", 13'h0005, 8'h00);

        wr(13'h0400, 8'h77);
        en = 1'b1; we = 1'b1; addr = 13'h0400; din = 8'h99;
        reset_n = 1'b0;
        #1;
        check("mid_reset_dout", 8'h00);
        tick();
        en = 1'b0; we = 1'b0;
        reset_n = 1'b1;
        rd_chk("reset_persist", 13'h0400, 8'h77);

        for (int i = 0; i < 8192; i++) begin
            logic [7:0] lo;
            lo = i[7:0];
            wr(i[12:0], lo ^ 8'h5A);
        end
        for (int i = 0; i < 8192 + LAT - 1; i++) begin
            if (i < 8192) begin
                en = 1'b1; we = 1'b0; addr = i[12:0];
            end else begin
                en = 1'b0; we = 1'b0;
            end
            tick();
            if (i >= LAT - 1) begin
                int k;
                logic [7:0] klo;
                k = i - (LAT - 1);
                klo = k[7:0];
                check($sformatf("sweep_%0h", k), klo ^ 8'h5A);
            end
        end
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
